// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, default rates and bit-period helper.
// Used by both the receive and transmit sides.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DEFAULT_CLK_HZ = 12000000;
  localparam int DEFAULT_BAUD   = 9600;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops
// load RESET_VAL under synchronous active-low reset.
`timescale 1ns/1ps
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic dout
);

  logic meta_reg;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      meta_reg <= RESET_VAL;
      dout     <= RESET_VAL;
    end else begin
      meta_reg <= din;
      dout     <= meta_reg;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// Oversampling 8N1 UART receiver with a one-byte valid/ready output holding register.
// Define UART_RX_PARITY_EN to receive an even-parity bit and add o_parity_err.
`timescale 1ns/1ps
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = DEFAULT_CLK_HZ,
  parameter int BAUD         = DEFAULT_BAUD,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD),
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       o_parity_err,
`endif
  output logic       o_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  logic          rx_s;
  logic [2:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;
  logic          deliver_reg;
`ifdef UART_RX_PARITY_EN
  logic          par_bit_reg;
`endif

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk  (i_clk),
    .nrst (i_nrst),
    .din  (i_rx),
    .dout (rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      deliver_reg <= 1'b0;
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_reg  <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      deliver_reg <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (!rx_s) begin
            state_reg <= ST_START;
            cnt_reg   <= '0;
            bit_reg   <= '0;
          end
        end
        ST_START: begin
          // A start bit still low at mid-bit is real; anything shorter is a glitch.
          if (cnt_reg == HALF_LAST) begin
            cnt_reg   <= '0;
            state_reg <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg   <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            bit_reg   <= bit_reg + 3'd1;
            if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= ST_PARITY;
`else
              state_reg <= ST_STOP;
`endif
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg     <= '0;
            par_bit_reg <= rx_s;
            state_reg   <= ST_STOP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg <= '0;
            if (rx_s) begin
              state_reg <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
              if (^{shift_reg, par_bit_reg}) o_parity_err <= 1'b1;
              else                           deliver_reg  <= 1'b1;
`else
              deliver_reg <= 1'b1;
`endif
            end else begin
              o_frame_err <= 1'b1;
              state_reg   <= ST_WAIT_HIGH;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_s) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase

      // Output holding register; shift_reg is stable here because IDLE never shifts.
      if (o_valid && i_ready) o_valid <= 1'b0;
      if (deliver_reg) begin
        if (!o_valid || i_ready) begin
          o_data  <= shift_reg;
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte at a scaled bit rate (8 clocks per bit).
// Honours UART_RX_PARITY_EN for the parity port and frame format.
`timescale 1ns/1ps
module tb_uart_rx_byte;

  localparam int CLK_HZ = 80;
  localparam int BAUD   = 10;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HALF   = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT = 2 + HALF + 9 * CPB + 1 + EXTRA * CPB;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       fe;
  logic       ov;
`ifdef UART_RX_PARITY_EN
  logic       pe;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int xfer_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .i_clk       (clk),
    .i_nrst      (nrst),
    .i_rx        (rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (ready),
    .o_frame_err (fe),
`ifdef UART_RX_PARITY_EN
    .o_parity_err(pe),
`endif
    .o_overrun   (ov)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every accepted byte and counts pulses.
  initial begin
    logic valid_prev;
    logic [7:0] expv;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_valid && ready) begin
        xfer_cnt++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_byte: got %02h, required no transfer", o_data);
        end else begin
          expv = exp_q.pop_front();
          if (o_data !== expv) begin
            miscompares++;
            $display("FAIL rx_data: got %02h, required %02h", o_data, expv);
          end else begin
            $display("rx byte %02h ok", o_data);
          end
        end
      end
      if (o_valid && !valid_prev) rise_cyc = cyc;
      valid_prev = o_valid;
      if (fe) fe_cnt++;
      if (ov) ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (pe) pe_cnt++;
`endif
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, expv);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_ok);
    rx = 1'b0;
    start_cyc = cyc + 1;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ ~par_ok;
    tick(CPB);
`else
    if (!par_ok) $display("note: parity request ignored in 8N1 build");
`endif
    rx = stop_bit;
    tick(CPB);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1);
    check("drain_pending", exp_q.size(), 0);
    tick(4);
  endtask

  initial begin
    int x0, f0, o0, p0, lat;
    tick(3);
    check("reset_data", o_data, 0);
    check("reset_valid", o_valid, 0);
    check("reset_frame_err", fe, 0);
    check("reset_overrun", ov, 0);
    nrst = 1'b1;
    tick(5);

    // Single byte with latency measurement
    x0 = xfer_cnt;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 1'b1);
    drain();
    check("a5_transfers", xfer_cnt - x0, 1);
    lat = rise_cyc - start_cyc;
    vectors++;
    if (lat < LAT - 2 || lat > LAT + 2) begin
      miscompares++;
      $display("FAIL a5_latency: got %0d, required %0d +/-2", lat, LAT);
    end else begin
      $display("check a5_latency = %0d ok", lat);
    end

    // All byte values with idle gaps
    x0 = xfer_cnt; f0 = fe_cnt; o0 = ov_cnt;
    for (int v = 0; v < 256; v++) begin
      exp_q.push_back(8'(v));
      send_byte(8'(v), 1'b1, 1'b1);
      tick(20);
    end
    drain();
    check("sweep_transfers", xfer_cnt - x0, 256);
    check("sweep_frame_err", fe_cnt - f0, 0);
    check("sweep_overrun", ov_cnt - o0, 0);

    // Short low glitch is ignored
    x0 = xfer_cnt; f0 = fe_cnt;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(3 * CPB);
    check("glitch_transfers", xfer_cnt - x0, 0);
    check("glitch_frame_err", fe_cnt - f0, 0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, 1'b1);
    drain();
    check("after_glitch_transfers", xfer_cnt - x0, 1);

    // Bad stop bit followed by a break
    x0 = xfer_cnt; f0 = fe_cnt;
    send_byte(8'h55, 1'b0, 1'b1);
    tick(3 * CPB);
    rx = 1'b1;
    tick(2 * CPB);
    check("break_frame_err", fe_cnt - f0, 1);
    check("break_transfers", xfer_cnt - x0, 0);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1, 1'b1);
    drain();
    check("after_break_frame_err", fe_cnt - f0, 1);
    check("after_break_transfers", xfer_cnt - x0, 1);

    // Overrun while consumer stalls
    x0 = xfer_cnt; o0 = ov_cnt;
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1, 1'b1);
    tick(10);
    send_byte(8'h22, 1'b1, 1'b1);
    tick(10);
    check("stall_data", o_data, 8'h11);
    check("stall_valid", o_valid, 1);
    check("stall_overrun", ov_cnt - o0, 1);
    check("stall_transfers", xfer_cnt - x0, 0);
    ready = 1'b1;
    drain();
    check("release_valid", o_valid, 0);
    check("release_transfers", xfer_cnt - x0, 1);

    // Reset in the middle of a data bit of 0xF0
    x0 = xfer_cnt;
    rx = 1'b0;
    tick(CPB);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b0;
    tick(CPB / 2);
    nrst = 1'b0;
    rx = 1'b1;
    tick(2);
    check("midreset_data", o_data, 0);
    check("midreset_valid", o_valid, 0);
    check("midreset_frame_err", fe, 0);
    check("midreset_overrun", ov, 0);
    nrst = 1'b1;
    tick(12 * CPB);
    check("midreset_transfers", xfer_cnt - x0, 0);
    exp_q.push_back(8'h0F);
    send_byte(8'h0F, 1'b1, 1'b1);
    drain();
    check("after_reset_transfers", xfer_cnt - x0, 1);

`ifdef UART_RX_PARITY_EN
    // Parity mismatch discards the byte
    x0 = xfer_cnt; p0 = pe_cnt;
    send_byte(8'h07, 1'b1, 1'b0);
    tick(2 * CPB);
    check("parity_err_pulses", pe_cnt - p0, 1);
    check("parity_err_transfers", xfer_cnt - x0, 0);
    exp_q.push_back(8'h07);
    send_byte(8'h07, 1'b1, 1'b1);
    drain();
    check("good_parity_pulses", pe_cnt - p0, 1);
    check("good_parity_transfers", xfer_cnt - x0, 1);
`else
    p0 = pe_cnt;
    check("no_parity_pulses", pe_cnt - p0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Oversampling UART receiver, 8N1, LSB first; the front stage that feeds the loopback path.
- Turns the asynchronous serial line into bytes presented on a valid/ready interface.
- Holds one received byte until it is accepted.
- Flags framing errors and overruns.
- Defaults: 12 MHz clock, 9600 baud.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- CLKS_PER_BIT, CLK_HZ/BAUD (1250), clocks per bit; must be ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2 (625), start-bit validation point.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_nrst  in  1  synchronous active-low reset, sampled on i_clk rising edge.
- i_rx  in  1  asynchronous serial input; idles high.
- o_data  out  8  received byte; stable while o_valid=1.
- o_valid  out  1  byte available.
- i_ready  in  1  consumer accepts o_data when o_valid & i_ready.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_overrun  out  1  one-cycle pulse: byte completed while previous byte still unaccepted.

Behaviour:
- Reset (i_nrst=0 at a clock edge):
  - Sync flops = 1; state = IDLE; counters = 0.
  - o_data = 0x00; o_valid = 0; o_frame_err = 0; o_overrun = 0.
  - Reset mid-frame aborts the frame with no output.
- i_rx passes a 2-flop synchronizer; rx_s is its output. All decisions use rx_s only.
- State machine:
  - IDLE: on rx_s=0 go to START, clear bit counter.
  - START: count to HALF_BIT-1. If rx_s=0 at that point, go to DATA with the counter cleared. Otherwise it is a glitch: return to IDLE, no flags.
  - DATA: at each count CLKS_PER_BIT-1, sample rx_s into shift[7] and shift right. After the 8th sample go to STOP.
  - STOP: at count CLKS_PER_BIT-1, sample rx_s.
    - rx_s=1: deliver the byte, go to IDLE.
    - rx_s=0: pulse o_frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. A held-low break yields exactly one frame_err.
- Delivery (cycle after the stop sample):
  - If o_valid=0, or o_valid & i_ready in that same cycle: load o_data, set o_valid=1.
  - Else: keep the old byte, drop the new one, pulse o_overrun for 1 cycle.
- Handshake:
  - Transfer occurs when o_valid & i_ready at a clock edge.
  - o_valid clears the next cycle unless a new byte loads in that same cycle.
  - o_data must not change while o_valid=1 and no transfer occurs.
- Latency: o_valid rises 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 clocks after the edge that first registers i_rx=0 (11878 at defaults).
- Counter width: $clog2(CLKS_PER_BIT). The counter never wraps; it is cleared on every bit boundary.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP; the 9th bit is even parity.
  - Adds output o_parity_err (1 bit, one-cycle pulse, reset 0).
  - On mismatch with a valid stop bit: pulse o_parity_err, discard the byte.
  - Frame error takes precedence over parity error; only o_frame_err pulses.
  - Latency grows by CLKS_PER_BIT.
- Undefined: 8N1 only; port o_parity_err absent.

Decomposition:
- Shared package uart_pkg:
  - State encodings IDLE/START/DATA/PARITY/STOP/WAIT_HIGH.
  - Default CLK_HZ and BAUD constants.
  - CLKS_PER_BIT function.
  - Reused by the tx side.
- One sub-module: uart_sync2, the 2-flop synchronizer with a reset value parameter (1 here).

Test Plan:
- Send 0xA5 at 9600 baud (104167 ns/bit), i_ready=1 → o_valid pulses once, o_data=0xA5, o_valid edge within 11878±2 clocks of the start edge.
- Send bytes 0x00..0xFF back-to-back with 100 µs idle gaps, i_ready=1 → 256 transfers in order, no frame_err/overrun.
- Drive i_rx low for 200 ns, then high → no o_valid, no o_frame_err; next byte 0x3C received correctly.
- Send 0x55 with stop bit forced 0, then hold line low 3 bit-times → exactly one o_frame_err pulse, no o_valid; following 0x81 received.
- i_ready=0, send 0x11 then 0x22 → o_data stays 0x11, one o_overrun pulse; raise i_ready → single transfer of 0x11, o_valid drops.
- Assert i_nrst=0 for 2 clocks mid-data-bit of 0xF0 → all outputs 0; the next full byte 0x0F is received correctly. With UART_RX_PARITY_EN defined, bad parity on 0x07 → o_parity_err pulse, no o_valid.
